// File: rtl/qext_pkg.sv
// rtl/qext_pkg.sv - state type and width helpers shared by the charge extractor.
// QEXT_PED_SUB_EN adds one bit to the charge word for per-lane pedestal subtraction.
package qext_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INTEG = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int q_width(input int in_w, input int lanes, input int win_max);
`ifdef QEXT_PED_SUB_EN
        return in_w + clog2(lanes * win_max) + 1;
`else
        return in_w + clog2(lanes * win_max);
`endif
    endfunction

    function automatic int wl_width(input int win_max);
        return clog2(win_max + 1);
    endfunction

endpackage

// File: rtl/qext_delay_line.sv
// rtl/qext_delay_line.sv - pre-trigger look-back shift register of {valid, lanes}.
// DEPTH=0 collapses to a wire so the accumulator sees the live input.
module qext_delay_line #(
    parameter int WIDTH = 125,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ RESET;
            assign dout_o         = din_i;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk) begin
                if (RESET) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= din_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign dout_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/q_window_extractor.sv
// rtl/q_window_extractor.sv - windowed multi-lane charge integrator with look-back and holdoff.
// QEXT_PED_SUB_EN adds a ped port subtracted from every lane, latched at the trigger edge.
module q_window_extractor
    import qext_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int IN_W        = 31,
    parameter int PRE_CYC     = 2,
    parameter int WIN_CYC_MAX = 16,
    parameter int HOLDOFF     = 4,
    parameter int TS_W        = 32,
    localparam int Q_W        = q_width(IN_W, LANES, WIN_CYC_MAX),
    localparam int WL_W       = wl_width(WIN_CYC_MAX)
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic [LANES*IN_W-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  trig,
    input  logic [TS_W-1:0]       ltc,
    input  logic [WL_W-1:0]       win_len,
`ifdef QEXT_PED_SUB_EN
    input  logic [IN_W-1:0]       ped,
`endif
    output logic                  busy,
    output logic                  q_valid,
    output logic [Q_W-1:0]        q_out,
    output logic [TS_W-1:0]       q_ts,
    output logic                  q_pileup
);

    localparam int HC_W = (clog2(HOLDOFF + 1) > 0) ? clog2(HOLDOFF + 1) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
    localparam logic [WL_W-1:0] W_MAX = WL_W'(WIN_CYC_MAX);
    localparam logic [WL_W-1:0] W_MIN = WL_W'(1);

    logic [LANES*IN_W:0]   d_word;
    logic [LANES*IN_W-1:0] d_data;
    logic                  d_valid;

    state_t          state_q, state_d;
    logic            trig_prev_q;
    logic [Q_W-1:0]  acc_q, acc_d;
    logic [WL_W-1:0] cnt_q, cnt_d, w_q, w_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic            pileup_q, pileup_d;
    logic [HC_W-1:0] hold_q, hold_d;
    logic            q_valid_q, q_valid_d;
    logic [Q_W-1:0]  q_out_q, q_out_d;
    logic [TS_W-1:0] q_ts_q, q_ts_d;
    logic            q_pileup_q, q_pileup_d;

    logic            trig_edge, start;
    logic [WL_W-1:0] win_clamped, w_cur, cnt_next;
    logic [Q_W-1:0]  lane_sum, acc_next;
    logic            pileup_cur;

    qext_delay_line #(
        .WIDTH (1 + LANES*IN_W),
        .DEPTH (PRE_CYC)
    ) u_delay (
        .clk    (clk),
        .RESET  (RESET),
        .din_i  ({in_valid, in_data}),
        .dout_o (d_word)
    );

    assign d_valid   = d_word[LANES*IN_W];
    assign d_data    = d_word[LANES*IN_W-1:0];
    assign trig_edge = trig & ~trig_prev_q;

`ifdef QEXT_PED_SUB_EN
    logic [IN_W-1:0] ped_q, ped_d, ped_eff;
    logic [IN_W:0]   lane_ext;

    // The trigger-cycle sample must already use the new pedestal.
    assign ped_eff = (state_q == IDLE) ? ped : ped_q;
`endif

    always_comb begin
        lane_sum = '0;
`ifdef QEXT_PED_SUB_EN
        lane_ext = '0;
`endif
        for (int i = 0; i < LANES; i++) begin
`ifdef QEXT_PED_SUB_EN
            lane_ext = {d_data[i*IN_W + IN_W - 1], d_data[i*IN_W +: IN_W]}
                     - {ped_eff[IN_W-1], ped_eff};
            lane_sum = lane_sum + {{(Q_W-IN_W-1){lane_ext[IN_W]}}, lane_ext};
`else
            lane_sum = lane_sum + {{(Q_W-IN_W){d_data[i*IN_W + IN_W - 1]}}, d_data[i*IN_W +: IN_W]};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q     <= IDLE;
            trig_prev_q <= 1'b1;
            acc_q       <= '0;
            cnt_q       <= '0;
            w_q         <= '0;
            ts_q        <= '0;
            pileup_q    <= 1'b0;
            hold_q      <= '0;
            q_valid_q   <= 1'b0;
            q_out_q     <= '0;
            q_ts_q      <= '0;
            q_pileup_q  <= 1'b0;
`ifdef QEXT_PED_SUB_EN
            ped_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            trig_prev_q <= trig;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            w_q         <= w_d;
            ts_q        <= ts_d;
            pileup_q    <= pileup_d;
            hold_q      <= hold_d;
            q_valid_q   <= q_valid_d;
            q_out_q     <= q_out_d;
            q_ts_q      <= q_ts_d;
            q_pileup_q  <= q_pileup_d;
`ifdef QEXT_PED_SUB_EN
            ped_q       <= ped_d;
`endif
        end
    end

    // The trigger cycle is itself the first counted sample, so IDLE and INTEG share one path.
    always_comb begin
        start = (state_q == IDLE) && trig_edge;
        if (win_len == '0) begin
            win_clamped = W_MIN;
        end else if (win_len > W_MAX) begin
            win_clamped = W_MAX;
        end else begin
            win_clamped = win_len;
        end
        w_cur      = start ? win_clamped : w_q;
        acc_next   = (start ? '0 : acc_q) + (d_valid ? lane_sum : '0);
        cnt_next   = (start ? '0 : cnt_q) + WL_W'(d_valid);
        pileup_cur = start ? 1'b0 : (pileup_q | trig_edge);

        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        w_d        = w_q;
        ts_d       = ts_q;
        pileup_d   = pileup_q;
        hold_d     = hold_q;
        q_valid_d  = 1'b0;
        q_out_d    = q_out_q;
        q_ts_d     = q_ts_q;
        q_pileup_d = q_pileup_q;
`ifdef QEXT_PED_SUB_EN
        ped_d      = start ? ped : ped_q;
`endif

        if (start || state_q == INTEG) begin
            acc_d    = acc_next;
            cnt_d    = cnt_next;
            w_d      = w_cur;
            pileup_d = pileup_cur;
            if (start) begin
                ts_d = ltc;
            end
            if (cnt_next == w_cur) begin
                q_valid_d  = 1'b1;
                q_out_d    = acc_next;
                q_ts_d     = start ? ltc : ts_q;
                q_pileup_d = pileup_cur;
                hold_d     = '0;
                state_d    = (HOLDOFF > 0) ? HOLD : IDLE;
            end else begin
                state_d = INTEG;
            end
        end else if (state_q == HOLD) begin
            if (hold_q == HOLD_LAST) begin
                state_d = IDLE;
            end else begin
                hold_d = hold_q + HC_W'(1);
            end
        end
    end

    always_comb begin
        busy     = (state_q != IDLE);
        q_valid  = q_valid_q;
        q_out    = q_out_q;
        q_ts     = q_ts_q;
        q_pileup = q_pileup_q;
    end

endmodule

// File: tb/tb_q_window_extractor.sv
// tb/tb_q_window_extractor.sv - directed bench checking the extractor against a window-scan model.
// Under QEXT_PED_SUB_EN the bench also drives ped and expects pedestal-subtracted sums.
module tb_q_window_extractor;
    import qext_pkg::*;

    localparam int LANES   = 4;
    localparam int IN_W    = 31;
    localparam int PRE     = 2;
    localparam int WMAX    = 16;
    localparam int HOLDOFF = 4;
    localparam int TS_W    = 32;
    localparam int Q_W     = q_width(IN_W, LANES, WMAX);
    localparam int WL_W    = wl_width(WMAX);
    localparam int N       = 440;
`ifdef QEXT_PED_SUB_EN
    localparam longint S7_Q = 28;
`else
    localparam longint S7_Q = 40;
`endif

    logic                  clk = 1'b0;
    logic                  RESET;
    logic [LANES*IN_W-1:0] in_data;
    logic                  in_valid;
    logic                  trig;
    logic [TS_W-1:0]       ltc;
    logic [WL_W-1:0]       win_len;
    logic                  busy, q_valid, q_pileup;
    logic [Q_W-1:0]        q_out;
    logic [TS_W-1:0]       q_ts;
`ifdef QEXT_PED_SUB_EN
    logic [IN_W-1:0]       ped;
`endif

    int  stim_lane [N][LANES];
    bit  stim_valid [N];
    bit  stim_trig [N];
    bit  stim_rst [N];
    int  stim_win [N];
    int  stim_ped [N];

    bit     ev_valid [N];
    longint ev_out [N];
    longint ev_ts [N];
    bit     ev_pile [N];
    bit     exp_busy [N];
    longint exp_out [N];
    longint exp_ts [N];
    bit     exp_pile [N];

    bit     obs_valid [N];
    bit     obs_busy [N];
    longint obs_out [N];
    longint obs_ts [N];
    bit     obs_pile [N];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    q_window_extractor dut (
        .clk      (clk),
        .RESET    (RESET),
        .in_data  (in_data),
        .in_valid (in_valid),
        .trig     (trig),
        .ltc      (ltc),
        .win_len  (win_len),
`ifdef QEXT_PED_SUB_EN
        .ped      (ped),
`endif
        .busy     (busy),
        .q_valid  (q_valid),
        .q_out    (q_out),
        .q_ts     (q_ts),
        .q_pileup (q_pileup)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int n, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, n, got, exp);
        end
    endtask

    task automatic fill_lanes(input int from, input int to, input int v);
        for (int n = from; n <= to; n++)
            for (int i = 0; i < LANES; i++) stim_lane[n][i] = v;
    endtask

    task automatic set_range(input int from, input int to, input int kind, input int v);
        for (int n = from; n <= to; n++) begin
            case (kind)
                0: stim_trig[n] = 1'b1;
                1: stim_rst[n]  = 1'b1;
                2: stim_win[n]  = v;
                default: stim_ped[n] = v;
            endcase
        end
    endtask

    task automatic build_stim();
        for (int n = 0; n < N; n++) begin
            stim_valid[n] = 1'b1;
            stim_trig[n]  = 1'b0;
            stim_rst[n]   = (n < 4);
            stim_win[n]   = 3;
            stim_ped[n]   = 0;
            for (int i = 0; i < LANES; i++) stim_lane[n][i] = 0;
        end
        fill_lanes(10, 69, 10);                    // S1: constant 10, win 3, edge at 30
        set_range(30, 32, 0, 0);
        for (int c = 0; c < 60; c++) fill_lanes(70 + c, 70 + c, c);   // S2: ramp, win 2, edge 90
        set_range(70, 129, 2, 2);
        set_range(90, 91, 0, 0);
        fill_lanes(130, 189, 5);                   // S3: gap at 150, edge 150
        stim_valid[150] = 1'b0;
        set_range(150, 152, 0, 0);
        fill_lanes(190, 249, 1);                   // S4: pile-up, holdoff, re-arm
        set_range(210, 210, 0, 0);
        set_range(212, 212, 0, 0);
        set_range(215, 215, 0, 0);
        set_range(218, 219, 0, 0);
        fill_lanes(250, 279, 7);                   // S5: win 0 then win 20 at full negative scale
        fill_lanes(280, 309, -(1 << 30));
        set_range(250, 279, 2, 0);
        set_range(280, 309, 2, 20);
        set_range(270, 270, 0, 0);
        set_range(290, 291, 0, 0);
        fill_lanes(320, 379, 10);                  // S6: abort by reset, trig held across reset
        set_range(340, 340, 0, 0);
        set_range(341, 341, 1, 0);
        set_range(350, 352, 1, 0);
        set_range(351, 360, 0, 0);
        fill_lanes(380, 439, 10);                  // S7: pedestal window
        set_range(380, 439, 2, 1);
        set_range(390, 410, 3, 3);
        set_range(400, 400, 0, 0);
    endtask

    function automatic bit edge_at(input int n);
        bit prev;
        prev = (n == 0) ? 1'b1 : (stim_rst[n-1] ? 1'b1 : stim_trig[n-1]);
        return stim_trig[n] & ~prev;
    endfunction

    function automatic bit d_ok(input int k);
        if (k < PRE) return 1'b0;
        for (int j = k - PRE; j < k; j++) if (stim_rst[j]) return 1'b0;
        return stim_valid[k-PRE];
    endfunction

    // Scan forward from each accepted edge, counting valid delayed samples until the window fills.
    task automatic compute_model();
        int ready, k, w, cnt, end_busy;
        longint acc, pedv, cur_out, cur_ts;
        bit pile, aborted, cur_pile;
        for (int n = 0; n < N; n++) begin
            ev_valid[n] = 0; exp_busy[n] = 0; ev_out[n] = 0; ev_ts[n] = 0; ev_pile[n] = 0;
        end
        ready = 0;
        for (int t = 0; t < N; t++) begin
            if (t < ready || stim_rst[t] || !edge_at(t)) continue;
            w = (stim_win[t] == 0) ? 1 : ((stim_win[t] > WMAX) ? WMAX : stim_win[t]);
`ifdef QEXT_PED_SUB_EN
            pedv = longint'(stim_ped[t]);
`else
            pedv = 0;
`endif
            cnt = 0; acc = 0; pile = 0; aborted = 0; k = t;
            while (1) begin
                if (k >= N - 1 || stim_rst[k]) begin aborted = 1; break; end
                if (k > t && edge_at(k)) pile = 1;
                if (d_ok(k)) begin
                    cnt++;
                    for (int i = 0; i < LANES; i++) acc += longint'(stim_lane[k-PRE][i]) - pedv;
                end
                if (cnt == w) break;
                k++;
            end
            if (aborted) begin
                for (int b = t + 1; b <= k && b < N; b++) exp_busy[b] = 1;
                ready = k + 1;
                continue;
            end
            ev_valid[k+1] = 1; ev_out[k+1] = acc; ev_ts[k+1] = 970 + t; ev_pile[k+1] = pile;
            end_busy = k + HOLDOFF;
            ready    = k + 1 + HOLDOFF;
            for (int r = k + 1; r <= k + HOLDOFF && r < N; r++)
                if (stim_rst[r]) begin end_busy = r; ready = r + 1; break; end
            for (int b = t + 1; b <= end_busy && b < N; b++) exp_busy[b] = 1;
        end
        cur_out = 0; cur_ts = 0; cur_pile = 0;
        for (int n = 0; n < N; n++) begin
            if (ev_valid[n]) begin
                cur_out = ev_out[n]; cur_ts = ev_ts[n]; cur_pile = ev_pile[n];
            end else if (n > 0 && stim_rst[n-1]) begin
                cur_out = 0; cur_ts = 0; cur_pile = 0;
            end
            exp_out[n] = cur_out; exp_ts[n] = cur_ts; exp_pile[n] = cur_pile;
        end
    endtask

    task automatic lit_ev(input string name, input int n, input longint q, input longint ts,
                          input bit pile);
        chk({name, "_model_q"}, n, ev_out[n], q);
        chk({name, "_valid"}, n, longint'(obs_valid[n]), 1);
        chk({name, "_q"}, n, obs_out[n], q);
        chk({name, "_ts"}, n, obs_ts[n], ts);
        chk({name, "_pileup"}, n, longint'(obs_pile[n]), longint'(pile));
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            obs_valid[cyc] = q_valid;
            obs_busy[cyc]  = busy;
            obs_out[cyc]   = longint'($signed(q_out));
            obs_ts[cyc]    = longint'(q_ts);
            obs_pile[cyc]  = q_pileup;
            chk("q_valid", cyc, longint'(q_valid), longint'(ev_valid[cyc]));
            chk("busy", cyc, longint'(busy), longint'(exp_busy[cyc]));
            chk("q_out", cyc, obs_out[cyc], exp_out[cyc]);
            chk("q_ts", cyc, obs_ts[cyc], exp_ts[cyc]);
            chk("q_pileup", cyc, longint'(q_pileup), longint'(exp_pile[cyc]));
        end
    end

    initial begin
        int tmp;
        int nvalid;
        build_stim();
        compute_model();
        for (int n = 0; n < N; n++) begin
            RESET    = stim_rst[n];
            in_valid = stim_valid[n];
            trig     = stim_trig[n];
            ltc      = TS_W'(970 + n);
            win_len  = WL_W'(stim_win[n]);
            for (int i = 0; i < LANES; i++) begin
                tmp = stim_lane[n][i];
                in_data[i*IN_W +: IN_W] = tmp[IN_W-1:0];
            end
`ifdef QEXT_PED_SUB_EN
            tmp = stim_ped[n];
            ped = tmp[IN_W-1:0];
`endif
            cyc = n;
            @(posedge clk);
            #1;
        end

        chk("reset_q_valid", 4, longint'(obs_valid[4]), 0);
        chk("reset_busy", 4, longint'(obs_busy[4]), 0);
        chk("reset_q_out", 4, obs_out[4], 0);
        chk("s1_early_valid", 32, longint'(obs_valid[32]), 0);
        lit_ev("s1", 33, 120, 1000, 0);
        lit_ev("s2", 92, 148, 1060, 0);
        chk("s3_gap_valid", 153, longint'(obs_valid[153]), 0);
        lit_ev("s3", 154, 60, 1120, 0);
        lit_ev("s4_pile", 213, 12, 1180, 1);
        lit_ev("s4_rearm", 221, 12, 1188, 0);
        lit_ev("s5_win0", 271, 28, 1240, 0);
        lit_ev("s5_full", 306, -(longint'(1) << 36), 1260, 0);
        chk("s6_busy_started", 341, longint'(obs_busy[341]), 1);
        chk("s6_busy_abort", 342, longint'(obs_busy[342]), 0);
        chk("s6_out_cleared", 342, obs_out[342], 0);
        nvalid = 0;
        for (int n = 320; n < 380; n++) nvalid += int'(obs_valid[n]);
        chk("s6_no_result", 379, longint'(nvalid), 0);
        lit_ev("s7_ped", 401, S7_Q, 1370, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
